ps2_mouse_rx_funcmod: RTL and testbench

PS2_MOUSE_RX_FUNCMOD -- requirements
Module: ps2_mouse_rx_funcmod

---
 rtl/ps2_mouse_rx_funcmod_pkg.sv | 31 +++
 rtl/ps2_mouse_rx_funcmod_frame_rx.sv | 84 ++++++++
 rtl/ps2_mouse_rx_funcmod.sv | 80 ++++++++
 tb/tb_ps2_mouse_rx_funcmod.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_rx_funcmod_pkg.sv
// Shared PS/2 receive definitions: timeout default, frame FSM encoding,
// and the decoded 3-byte mouse packet.
package ps2_mouse_rx_funcmod_pkg;

  localparam logic [16:0] T_TIMEOUT_DEF = 17'd100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
  } mouse_pkt_t;

  function automatic mouse_pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    mouse_pkt_t p;
    p.btn = b0[2:0];
    p.dx  = {b0[4], b1};
    p.dy  = {b0[5], b2};
    p.ovf = b0[7:6];
    return p;
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_funcmod_frame_rx.sv
// One PS/2 device-to-host frame: sync, falling-edge detect, 11-bit frame FSM,
// odd parity and inter-edge timeout. byte_valid/byte_err flag the deciding cycle.
module ps2_frame_rx
  import ps2_mouse_rx_funcmod_pkg::*;
#(
  parameter logic [16:0] T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  logic [1:0]   clk_sync, dat_sync;
  logic         clk_prev;
  frame_state_t state;
  logic [2:0]   bit_idx;
  logic [7:0]   shreg;
  logic         par_ok;
  logic [16:0]  cnt;

  logic fall, dat, timeout, edge_ok, stop_edge;

  assign fall      = clk_prev & ~clk_sync[1];
  assign dat       = dat_sync[1];
  assign timeout   = en && (state != ST_IDLE) && (cnt == T_TIMEOUT - 17'd1);
  // A timeout wins over an edge landing in the same cycle; that edge is dropped.
  assign edge_ok   = en && fall && !timeout;
  assign stop_edge = edge_ok && (state == ST_STOP);

  assign rx_byte    = shreg;
  assign byte_valid = stop_edge && dat && par_ok;
  assign byte_err   = timeout || (stop_edge && !(dat && par_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      cnt     <= '0;
    end else if (timeout) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      cnt <= (state == ST_IDLE || fall) ? 17'd0 : cnt + 17'd1;
      if (edge_ok) begin
        case (state)
          ST_IDLE: if (!dat) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
          ST_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= (^shreg) ^ dat;
            state  <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_rx_funcmod.sv
// PS/2 mouse receiver: collects three good bytes into a movement packet and
// presents it with a one-cycle oTrig; any frame error pulses oErr and resyncs.
module ps2_mouse_rx_funcmod
  import ps2_mouse_rx_funcmod_pkg::*;
#(
  parameter logic [16:0] T_TIMEOUT  = T_TIMEOUT_DEF,
  parameter logic        SYNC_CHECK = 1'b1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iEn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [2:0] oBtn,
  output logic [8:0] oDX,
  output logic [8:0] oDY,
  output logic [1:0] oOvf,
  output logic       oTrig,
  output logic       oErr
);

  logic [7:0] rx_byte;
  logic       byte_valid, byte_err;
  logic [1:0] idx;
  logic [7:0] b0, b1;
  mouse_pkt_t pkt;

  ps2_frame_rx #(.T_TIMEOUT(T_TIMEOUT)) u_frame (
    .clk(CLOCK), .rst(RESET), .en(iEn),
    .ps2_clk(PS2_CLK), .ps2_dat(PS2_DAT),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .byte_err(byte_err)
  );

  assign pkt = decode_pkt(b0, b1, rx_byte);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      idx   <= '0;
      b0    <= '0;
      b1    <= '0;
      oBtn  <= '0;
      oDX   <= '0;
      oDY   <= '0;
      oOvf  <= '0;
      oTrig <= 1'b0;
      oErr  <= 1'b0;
    end else if (!iEn) begin
      idx   <= '0;
      oTrig <= 1'b0;
      oErr  <= 1'b0;
    end else begin
      oTrig <= 1'b0;
      oErr  <= byte_err;
      if (byte_err) begin
        idx <= '0;
      end else if (byte_valid) begin
        case (idx)
          // Bit 3 of the first byte is always set; a clear bit means we are mid-packet.
          2'd0: if (!SYNC_CHECK || rx_byte[3]) begin
            b0  <= rx_byte;
            idx <= 2'd1;
          end
          2'd1: begin
            b1  <= rx_byte;
            idx <= 2'd2;
          end
          default: begin
            oBtn  <= pkt.btn;
            oDX   <= pkt.dx;
            oDY   <= pkt.dy;
            oOvf  <= pkt.ovf;
            oTrig <= 1'b1;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx_funcmod.sv
// Directed PS/2 mouse packets with a scoreboard queue of expected packets;
// a negedge monitor pops and compares on every oTrig and counts oErr pulses.
module tb_ps2_mouse_rx_funcmod;

  localparam logic [16:0] TMO = 17'd400;
  localparam int HP = 20;  // PS/2 half period in system clocks (scaled-down bus speed)

  typedef struct {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
  } exp_t;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       iEn = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [2:0] oBtn;
  logic [8:0] oDX, oDY;
  logic [1:0] oOvf;
  logic       oTrig, oErr;

  int   n_chk = 0;
  int   n_fail = 0;
  int   err_seen = 0;
  exp_t exp_q[$];

  ps2_mouse_rx_funcmod #(.T_TIMEOUT(TMO), .SYNC_CHECK(1'b1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iEn(iEn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .oBtn(oBtn), .oDX(oDX), .oDY(oDY), .oOvf(oOvf), .oTrig(oTrig), .oErr(oErr)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (oErr === 1'b1) err_seen++;
    if (oTrig === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_trig: got oTrig=1 expected no packet (dx=0x%0h dy=0x%0h)", oDX, oDY);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pkt_btn", int'(oBtn), int'(e.btn));
        chk("pkt_dx",  int'(oDX),  int'(e.dx));
        chk("pkt_dy",  int'(oDY),  int'(e.dy));
        chk("pkt_ovf", int'(oOvf), int'(e.ovf));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    cycles(HP);
    PS2_CLK = 1'b0;
    cycles(HP);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    cycles(2 * HP);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    PS2_DAT = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(c, 1'b0);
  endtask

  task automatic expect_pkt(input logic [2:0] btn, input logic [8:0] dx,
                            input logic [8:0] dy, input logic [1:0] ovf);
    exp_t e;
    e.btn = btn; e.dx = dx; e.dy = dy; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic phase_end(input string name, input int exp_err);
    cycles(4 * HP);
    chk({name, "_err_count"}, err_seen, exp_err);
    chk({name, "_pending_pkts"}, exp_q.size(), 0);
    err_seen = 0;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_btn"}, int'(oBtn), 0);
    chk({name, "_dx"},  int'(oDX),  0);
    chk({name, "_dy"},  int'(oDY),  0);
    chk({name, "_ovf"}, int'(oOvf), 0);
    chk({name, "_trig"}, int'(oTrig), 0);
    chk({name, "_err"},  int'(oErr),  0);
  endtask

  initial begin
    cycles(4);
    chk_outputs_zero("reset");
    RESET = 1'b0;
    cycles(4);
    iEn = 1'b1;
    cycles(4);

    // good packet: left button, dx=+5, dy=-2
    expect_pkt(3'b001, 9'h005, 9'h1FE, 2'b00);
    send_pkt(8'h29, 8'h05, 8'hFE);
    phase_end("good", 0);

    // parity error then recovery
    send_byte(8'h00, 1'b1);
    expect_pkt(3'b000, 9'h001, 9'h001, 2'b00);
    send_pkt(8'h08, 8'h01, 8'h01);
    phase_end("parity", 1);

    // sync loss: leading byte without bit3 is dropped silently
    send_byte(8'h00, 1'b0);
    expect_pkt(3'b000, 9'h010, 9'h020, 2'b00);
    send_pkt(8'h08, 8'h10, 8'h20);
    phase_end("sync", 0);

    // timeout mid-frame, then a packet with both overflow bits
    send_partial(8'h0F, 4);
    cycles(int'(TMO) + 200);
    expect_pkt(3'b000, 9'h07F, 9'h080, 2'b11);
    send_pkt(8'hC8, 8'h7F, 8'h80);
    phase_end("timeout", 1);

    // gated reception is ignored; the same packet decodes once enabled
    iEn = 1'b0;
    cycles(4);
    send_pkt(8'h1F, 8'hFF, 8'h00);
    phase_end("gated", 0);
    iEn = 1'b1;
    cycles(4);
    expect_pkt(3'b111, 9'h1FF, 9'h000, 2'b00);
    send_pkt(8'h1F, 8'hFF, 8'h00);
    phase_end("enabled", 0);

    // reset in the middle of byte1
    send_byte(8'h29, 1'b0);
    send_partial(8'h05, 3);
    RESET = 1'b1;
    cycles(1);
    RESET = 1'b0;
    cycles(1);
    chk_outputs_zero("midreset");
    cycles(2 * HP);
    phase_end("midreset", 0);
    expect_pkt(3'b001, 9'h002, 9'h003, 2'b00);
    send_pkt(8'h09, 8'h02, 8'h03);
    phase_end("after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
